// File: rtl/fetch_staged.sv
// Instruction-fetch stage with IF/DEC pipeline register; applies redirects resolved in DEC.
// Define FETCH_FLUSH_EN to squash the delay-slot word on a taken redirect (1-bubble penalty).
module fetch_staged #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        BrTaken,
    input  logic        UncondBr,
    input  logic        pc_rd,
    input  logic [63:0] Reg2,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic [63:0] pc_dec,
    output logic [63:0] PCPlusFour,
    output logic        valid_dec
);

    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_dec_q, pc_dec_d;
    logic [63:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [63:0] pc_plus4;
    logic [63:0] br_off;
    logic [63:0] br_target;
    logic [63:0] target;
    logic        redirect;

    assign pc_plus4 = pc_q + 64'd4;

    // Target is computed from the branch currently held in the IF/DEC register.
    always_comb begin
        if (UncondBr) begin
            br_off = {{38{instr_q[25]}}, instr_q[25:0]};
        end else begin
            br_off = {{45{instr_q[23]}}, instr_q[23:5]};
        end
        br_target = pc_dec_q + {br_off[61:0], 2'b00};
        target    = pc_rd ? Reg2 : br_target;
        redirect  = BrTaken | pc_rd;
    end

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = redirect ? target : pc_plus4;
        end
    end

    always_comb begin
        instr_d  = instr_q;
        pc_dec_d = pc_dec_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        if (!stall) begin
            pc_dec_d = pc_q;
            pc4_d    = pc_plus4;
`ifdef FETCH_FLUSH_EN
            if (redirect) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_data;
                valid_d = 1'b1;
            end
`else
            // The word fetched alongside a redirect is the architectural delay slot.
            instr_d = imem_data;
            valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_dec_q <= 64'd0;
            pc4_q    <= 64'd0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_dec_q <= pc_dec_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_dec      = pc_dec_q;
    assign PCPlusFour  = pc4_q;
    assign valid_dec   = valid_q;

endmodule

// File: tb/tb_fetch_staged.sv
// Scoreboard bench for fetch_staged: architectural model predicts each edge, monitor compares.
module tb_fetch_staged;

    localparam logic [63:0] RPC = 64'h100;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, BrTaken, UncondBr, pc_rd;
    logic [63:0] Reg2;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [63:0] pc_dec, PCPlusFour;
    logic        valid_dec;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pcd;
        logic [63:0] pc4;
        logic        valid;
        logic [63:0] addr;
    } exp_t;

    exp_t sb_q[$];

    // Model state: architectural PC and the word/PC visible in DEC.
    logic [63:0] m_pc, m_pcd, m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;

    fetch_staged #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .BrTaken(BrTaken), .UncondBr(UncondBr),
        .pc_rd(pc_rd), .Reg2(Reg2), .imem_addr(imem_addr), .imem_data(imem_data),
        .instruction(instruction), .pc_dec(pc_dec), .PCPlusFour(PCPlusFour),
        .valid_dec(valid_dec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h200: return 32'h14000003;                    // B  #3
            64'h300: return {8'hB4, 19'h7FFFE, 5'd0};        // CBZ #-2
            default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5BD1E995;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RPC;
        m_instr = NOP;
        m_pcd   = 64'd0;
        m_pc4   = 64'd0;
        m_valid = 1'b0;
    endtask

    // Called at a negedge: drive inputs, predict state after next edge, wait to next negedge.
    task automatic step(input logic s, input logic br, input logic unc, input logic rd,
                        input logic [63:0] r2);
        exp_t e;
        logic signed [25:0] s26;
        logic signed [18:0] s19;
        longint off;
        logic [63:0] tgt;
        stall = s; BrTaken = br; UncondBr = unc; pc_rd = rd; Reg2 = r2;
        if (!s) begin
            s26 = m_instr[25:0];
            s19 = m_instr[23:5];
            off = unc ? longint'(s26) : longint'(s19);
            tgt = rd ? r2 : m_pcd + 64'(off * 4);
`ifdef FETCH_FLUSH_EN
            m_instr = (br | rd) ? NOP : mem_word(m_pc);
            m_valid = !(br | rd);
`else
            m_instr = mem_word(m_pc);
            m_valid = 1'b1;
`endif
            m_pcd = m_pc;
            m_pc4 = m_pc + 64'd4;
            m_pc  = (br | rd) ? tgt : m_pc + 64'd4;
        end
        e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4; e.valid = m_valid; e.addr = m_pc;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_instr"}, 64'(instruction), 64'(NOP));
        chk({tag, "_valid"}, 64'(valid_dec), 64'd0);
        chk({tag, "_pcdec"}, pc_dec, 64'd0);
        chk({tag, "_pc4"}, PCPlusFour, 64'd0);
        chk({tag, "_addr"}, imem_addr, RPC);
    endtask

    // Monitor: one expected entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_instr", 64'(instruction), 64'(e.instr));
                chk("sb_pcdec", pc_dec, e.pcd);
                chk("sb_pc4", PCPlusFour, e.pc4);
                chk("sb_valid", 64'(valid_dec), 64'(e.valid));
                chk("sb_addr", imem_addr, e.addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a0;
        logic [31:0] i0;
        reset = 1'b1; stall = 0; BrTaken = 0; UncondBr = 0; pc_rd = 0; Reg2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_state("rst0");
        reset = 1'b0;

        // Sequential fetch from RESET_PC.
        repeat (3) step(0, 0, 0, 0, 0);
        chk("seq_pcdec", pc_dec, 64'h108);

        // Unconditional B #3 at 0x200.
        step(0, 0, 0, 1, 64'h200);
        step(0, 0, 0, 0, 0);
        chk("b_in_dec", 64'(instruction), 64'h14000003);
        step(0, 1, 1, 0, 0);
        chk("b_target", imem_addr, 64'h20C);
`ifdef FETCH_FLUSH_EN
        chk("b_flush_valid", 64'(valid_dec), 64'd0);
        chk("b_flush_instr", 64'(instruction), 64'(NOP));
`else
        chk("b_slot_pc", pc_dec, 64'h204);
        chk("b_slot_valid", 64'(valid_dec), 64'd1);
`endif
        step(0, 0, 0, 0, 0);
        chk("b_tgt_dec", pc_dec, 64'h20C);

        // CBZ #-2 at 0x300.
        step(0, 0, 0, 1, 64'h300);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("cb_target", imem_addr, 64'h2F8);

        // Register-indirect wins over UncondBr.
        step(0, 1, 1, 1, 64'hDEAD0);
        chk("br_target", imem_addr, 64'hDEAD0);

        // Stall with BrTaken asserted throughout: freeze, then exactly one redirect.
        step(0, 0, 0, 1, 64'h200);
        step(0, 0, 0, 0, 0);
        a0 = imem_addr;
        i0 = instruction;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1, 0, 0);
            chk("stall_addr", imem_addr, a0);
            chk("stall_instr", 64'(instruction), 64'(i0));
        end
        step(0, 1, 1, 0, 0);
        chk("stall_redirect", imem_addr, 64'h20C);
        step(0, 0, 0, 0, 0);
        chk("stall_no_dup", imem_addr, 64'h210);

        // PC wrap at 2^64.
        step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc", imem_addr, 64'h0);
        chk("wrap_pc4", PCPlusFour, 64'h0);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                reset = 1'b1;
                #2;
                chk_reset_state("rst_mid");
                @(negedge clk);
                chk_reset_state("rst_hold");
                reset = 1'b0;
                model_reset();
                step(0, 0, 0, 0, 0);
                chk("rst_first", pc_dec, RPC);
            end
            step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 1'($urandom),
                 $urandom_range(0, 19) == 0,
                 {$urandom, $urandom} & ($urandom_range(0, 3) == 0 ? '1 : ~64'h3));
        end

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
